// File: rtl/bus_drive_arbiter.sv
// Round-robin owner scheduler for the emulated tristate bus: converts driver requests into
// one-hot active-low enables with a fixed all-released gap, and flags contention on the net.
module bus_drive_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 0
) (
    input  logic                     i_clk,
    input  logic                     i_nrst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_bus_noe,
    output logic [N_REQ-1:0]         o_noe,
    output logic [$clog2(N_REQ)-1:0] o_owner,
    output logic                     o_owner_valid,
    output logic                     o_conflict
);

    localparam int OW = $clog2(N_REQ);
    localparam int HW = 16;
    localparam logic [3:0]    TURN_INIT   = 4'(TURNAROUND);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST   = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
    localparam logic [OW-1:0] LAST_IDX    = OW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  noe_q, noe_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic              valid_q, valid_d;
    logic              conflict_q, conflict_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [3:0]        turn_q, turn_d;

    logic              win_found;
    logic [OW-1:0]     win_idx;
    logic [OW-1:0]     scan_idx;
    logic [N_REQ-1:0]  owner_mask;
    logic              other_req;
    logic              release_now;
    logic [N_REQ-1:0]  bus_low;
    logic              multi_low;

    // Round-robin scan starting at rr_ptr; first requesting driver wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = OW'((int'(rr_ptr_q) + i) % N_REQ);
            if (!win_found && i_req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
        other_req           = |(i_req & ~owner_mask);
        release_now = !i_req[owner_q] ||
                      ((MAX_HOLD != 0) && (hold_q >= HOLD_LAST) && other_req);
        bus_low   = ~i_bus_noe;
        multi_low = |(bus_low & (bus_low - N_REQ'(1)));
    end

    always_comb begin
        state_d    = state_q;
        noe_d      = noe_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_d     = hold_q;
        turn_d     = turn_q;
        conflict_d = conflict_q | multi_low;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    noe_d          = '1;
                    noe_d[win_idx] = 1'b0;
                    owner_d        = win_idx;
                    hold_d         = '0;
                    state_d        = GRANT;
                end
            end
            GRANT: begin
                if ((MAX_HOLD != 0) && (hold_q < HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                end
                if (release_now) begin
                    noe_d    = '1;
                    rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                    turn_d   = TURN_INIT;
                    hold_d   = '0;
                    state_d  = TURN;
                end
            end
            TURN: begin
                noe_d  = '1;
                turn_d = turn_q - 1'b1;
                // Requests are only sampled on the last gap cycle so the gap length is exact.
                if (turn_q <= 4'd1) begin
                    turn_d = '0;
                    if (win_found) begin
                        noe_d[win_idx] = 1'b0;
                        owner_d        = win_idx;
                        hold_d         = '0;
                        state_d        = GRANT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                noe_d   = '1;
                state_d = IDLE;
            end
        endcase

        valid_d = ~&noe_d;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= IDLE;
            noe_q      <= '1;
            owner_q    <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            rr_ptr_q   <= '0;
            hold_q     <= '0;
            turn_q     <= '0;
        end else begin
            state_q    <= state_d;
            noe_q      <= noe_d;
            owner_q    <= owner_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
        end
    end

    assign o_noe         = noe_q;
    assign o_owner       = owner_q;
    assign o_owner_valid = valid_q;
    assign o_conflict    = conflict_q;

endmodule
